byte_serializer: RTL and testbench
==================================

BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 Parameter DATA_W, default 8: parallel word width in bits, minimum 2.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit DATA_W-1 is sent first, 0 = bit 0 is sent first.
REQ-003 Parameter FIFO_DEPTH, default 2: input buffer entries, a power of two, minimum 2.
REQ-004 clk  in  1  clock; all logic rising-edge.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 in_data  in  DATA_W  parallel word to serialize.
REQ-007 in_valid  in  1  in_data is valid.
REQ-008 in_ready  out  1  block can accept a word this cycle.
REQ-009 bit_en  in  1  pacing strobe; one bit may be emitted per cycle with bit_en=1.
REQ-010 flush  in  1  synchronous abort: drop the buffered words and the in-flight word.
REQ-011 seq  out  1  serial data bit, feeds the downstream sequence detector's seq input.
REQ-012 seq_valid  out  1  seq is valid, feeds the downstream detector's valid input.
REQ-013 busy  out  1  a word is in the shifter or the FIFO is non-empty.

Function
REQ-014 A word shall be accepted at a rising edge where in_valid=1 and in_ready=1, and not otherwise.
REQ-015 in_ready shall be 1 exactly when the FIFO is not full and flush=0; it is combinational from registered state and flush only, never from in_valid.
REQ-016 The FSM shall have two states, StIdle and StShift, plus a bit counter of width clog2(DATA_W).
REQ-017 In StIdle with the FIFO non-empty: pop the head into the shift register, set the counter to DATA_W-1, and go to StShift; seq_valid=0 in this cycle.
REQ-018 In StShift: seq_valid = bit_en, combinationally.
REQ-019 seq shall be the current output bit: shift-register MSB when MSB_FIRST=1, LSB when MSB_FIRST=0.
REQ-020 In StShift with bit_en=1 and counter>0: shift by one toward the output end and decrement the counter.
REQ-021 In StShift with bit_en=0: hold state, counter, and shift register; seq keeps its value.
REQ-022 On the last bit (counter=0, bit_en=1) with the FIFO non-empty: pop and load the next word in the same edge and stay in StShift, with no bubble between words.
REQ-023 On the last bit (counter=0, bit_en=1) with the FIFO empty: go to StIdle.
REQ-024 Latency: a word accepted at edge N into an empty block in StIdle shall have its first bit with seq_valid=1 in the cycle after edge N+1, given bit_en=1.
REQ-025 The FIFO shall have no write-to-read bypass.
REQ-026 A push and a pop in the same edge shall be legal when the FIFO is neither empty nor full, and the occupancy is then unchanged.
REQ-027 Pop only from a non-empty FIFO; push only to a non-full FIFO.
REQ-028 flush=1 at an edge shall empty the FIFO, go to StIdle, and clear the counter; any push in the same cycle is blocked (in_ready=0).
REQ-029 busy = (state==StShift) OR FIFO non-empty.

Reset
REQ-030 On resetn=0 (asynchronous, including mid-word) the block shall enter StIdle with the FIFO empty, the counter at 0, and the shift register at 0.
REQ-031 During and after reset: seq=0, seq_valid=0, busy=0, in_ready=1 (with flush=0).

Structure
REQ-032 Shared package serializer_pkg shall hold the state enum (StIdle, StShift) and the default DATA_W constant.
REQ-033 The FIFO shall be a separate sub-module, sync_fifo, parameterised on width and depth, with push, pop, full, and empty ports.
REQ-034 The FSM, counter, and shift register shall live in byte_serializer.

Verification
REQ-035 Single word: MSB_FIRST=1, bit_en=1, push 0xB6 -> seq=1,0,1,1,0,1,1,0 on 8 consecutive seq_valid cycles; the downstream detector flags 10110 at the 5th bit; then busy=0.
REQ-036 Back-to-back: push 0xB6 and then 0x5A with bit_en=1 -> 16 consecutive seq_valid=1 cycles, bits 10110110 01011010, no gap.
REQ-037 Pacing: bit_en alternating 1,0 with 0xB6 -> seq_valid asserted only on bit_en cycles; 8 bits over 15 cycles, order unchanged.
REQ-038 Backpressure: FIFO_DEPTH=2, bit_en=0, in_valid held high with 4 words -> 3 accepted (1 in the shifter, 2 in the FIFO), then in_ready=0 until the first word's last bit is sent.
REQ-039 Flush and reset: flush after 3 bits of 0xB6 with 0x5A buffered -> next edge seq_valid=0, busy=0, in_ready=1, no further bits; asserting resetn=0 mid-word gives the same outputs asynchronously.
REQ-040 LSB-first: MSB_FIRST=0, push 0xB6 -> seq=0,1,1,0,1,1,0,1.

Source files
------------

// File: rtl/serializer_pkg.sv
// serializer_pkg: shared state encoding and default word width for the serializer.
package serializer_pkg;
  typedef enum logic {StIdle, StShift} state_t;
  localparam int DEF_DATA_W = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: registered-output-free FIFO with no write-to-read bypass and synchronous flush.
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign empty = wp == rp;
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  assign rdata = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= do_push ? wp + 1'b1 : wp;
      rp <= do_pop ? rp + 1'b1 : rp;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= wdata;
endmodule

// File: rtl/byte_serializer.sv
// byte_serializer: buffers parallel words and shifts them out one bit per bit_en strobe.
module byte_serializer
  import serializer_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int MSB_FIRST = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              bit_en,
  input  logic              flush,
  output logic              seq,
  output logic              seq_valid,
  output logic              busy
);
  localparam int CW = $clog2(DATA_W);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] sh, sh_n, head, shifted;
  logic full, empty, pop, push;
  assign in_ready = !full && !flush;
  assign push = in_valid && in_ready;
  assign busy = (state == StShift) || !empty;
  assign seq = (MSB_FIRST != 0) ? sh[DATA_W-1] : sh[0];
  assign shifted = (MSB_FIRST != 0) ? {sh[DATA_W-2:0], 1'b0} : {1'b0, sh[DATA_W-1:1]};
  sync_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .resetn(resetn), .flush(flush), .push(push), .pop(pop),
    .wdata(in_data), .rdata(head), .full(full), .empty(empty)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= StIdle;
      cnt <= '0;
      sh <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      sh <= sh_n;
    end
  // Last bit with a word waiting reloads in the same edge so words run back-to-back.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    sh_n = sh;
    pop = 1'b0;
    seq_valid = (state == StShift) && bit_en;
    if (flush) begin
      state_n = StIdle;
      cnt_n = '0;
      sh_n = '0;
    end else if ((state == StIdle || (bit_en && cnt == '0)) && !empty) begin
      pop = 1'b1;
      sh_n = head;
      cnt_n = CW'(DATA_W - 1);
      state_n = StShift;
    end else if (state == StShift && bit_en) begin
      sh_n = shifted;
      cnt_n = (cnt != '0) ? cnt - 1'b1 : cnt;
      state_n = (cnt != '0) ? StShift : StIdle;
    end
  end
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: directed vector table plus multi-cycle corner sequences for both bit orders.
module tb_byte_serializer;
  logic clk = 1'b0;
  logic resetn, in_valid, bit_en, flush;
  logic [7:0] in_data;
  logic rdy, seq, sv, busy, rdy_l, seq_l, sv_l, busy_l;
  logic rdy_s, seq_s, sv_s, busy_s, rdy_ls, seq_ls, sv_ls, busy_ls;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  byte_serializer #(.DATA_W(8), .MSB_FIRST(1), .FIFO_DEPTH(2)) dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy),
    .bit_en(bit_en), .flush(flush), .seq(seq), .seq_valid(sv), .busy(busy)
  );
  byte_serializer #(.DATA_W(8), .MSB_FIRST(0), .FIFO_DEPTH(2)) dut_lsb (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy_l),
    .bit_en(bit_en), .flush(flush), .seq(seq_l), .seq_valid(sv_l), .busy(busy_l)
  );

  typedef struct {
    logic [7:0] word;
    logic       pace;
    logic [7:0] exp_m;
    logic [7:0] exp_l;
  } vec_t;
  vec_t vt [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic iv, input logic [7:0] d, input logic be, input logic fl);
    @(negedge clk);
    in_valid = iv;
    in_data = d;
    bit_en = be;
    flush = fl;
    #1;
    rdy_s = rdy; seq_s = seq; sv_s = sv; busy_s = busy;
    rdy_ls = rdy_l; seq_ls = seq_l; sv_ls = sv_l; busy_ls = busy_l;
  endtask

  initial begin
    logic [7:0] got_m, got_l, wd;
    logic [15:0] got16;
    int nm, nl, first, lastc, nbad, acc, wt, gap;
    logic be_v;
    vt[0] = '{8'hB6, 1'b0, 8'hB6, 8'h6D};
    vt[1] = '{8'hB6, 1'b1, 8'hB6, 8'h6D};
    vt[2] = '{8'h5A, 1'b0, 8'h5A, 8'h5A};
    vt[3] = '{8'h01, 1'b1, 8'h01, 8'h80};
    vt[4] = '{8'hF0, 1'b0, 8'hF0, 8'h0F};
    resetn = 1'b0; in_valid = 1'b0; in_data = '0; bit_en = 1'b0; flush = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_seq", seq, 0); chk("rst_sv", sv, 0); chk("rst_busy", busy, 0); chk("rst_ready", rdy, 1);
    chk("rst_lsb_busy", busy_l, 0);
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < 5; i++) begin
      got_m = '0; got_l = '0; nm = 0; nl = 0; first = -1; lastc = -1; nbad = 0;
      cycle(1'b1, vt[i].word, 1'b1, 1'b0);
      chk("push_ready", rdy_s, 1);
      for (int k = 0; k < 60 && (nm < 8 || nl < 8); k++) begin
        be_v = vt[i].pace ? k[0] : 1'b1;
        cycle(1'b0, 8'h00, be_v, 1'b0);
        if (sv_s && !be_v) nbad++;
        if (sv_s) begin
          got_m = {got_m[6:0], seq_s};
          nm++;
          if (first < 0) first = k;
          lastc = k;
          if (nm == 5 && vt[i].word == 8'hB6) chk("detect_10110", 32'(got_m[4:0]), 5'b10110);
        end
        if (sv_ls) begin
          got_l = {got_l[6:0], seq_ls};
          nl++;
        end
      end
      chk("bit_count", nm, 8);
      chk("bits_msb", got_m, vt[i].exp_m);
      chk("bits_lsb", got_l, vt[i].exp_l);
      chk("latency", first, 1);
      chk("span", lastc - first + 1, vt[i].pace ? 15 : 8);
      chk("sv_only_on_en", nbad, 0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("done_busy", busy_s, 0);
      chk("done_busy_lsb", busy_ls, 0);
    end

    // back-to-back words
    cycle(1'b1, 8'hB6, 1'b1, 1'b0);
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    chk("b2b_second_ready", rdy_s, 1);
    got16 = '0; nm = 0; gap = 0;
    for (int k = 0; k < 60 && nm < 16; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      if (sv_s) begin
        got16 = {got16[14:0], seq_s};
        nm++;
      end else if (nm > 0) gap++;
    end
    chk("b2b_count", nm, 16);
    chk("b2b_bits", got16, 16'hB65A);
    chk("b2b_gap", gap, 0);
    for (int k = 0; k < 40 && (busy_s || busy_ls); k++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("b2b_drain", busy_s, 0);

    // backpressure with bit_en held low
    acc = 0; wd = 8'hA1;
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, wd, 1'b0, 1'b0);
      if (rdy_s) begin
        acc++;
        wd++;
      end
    end
    chk("bp_accepted", acc, 3);
    chk("bp_ready_low", rdy_s, 0);
    chk("bp_busy", busy_s, 1);
    got_m = '0; nm = 0; wt = -1;
    for (int k = 0; k < 40 && wt < 0; k++) begin
      cycle(1'b1, wd, 1'b1, 1'b0);
      if (rdy_s) wt = k;
      else if (sv_s) begin
        got_m = {got_m[6:0], seq_s};
        nm++;
      end
    end
    chk("bp_ready_return", wt, 8);
    chk("bp_first_word", got_m, 8'hA1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("flush_blocks_ready", rdy_s, 0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("bp_flush_busy", busy_s, 0);
    chk("bp_flush_ready", rdy_s, 1);

    // flush after 3 bits with a word buffered
    cycle(1'b1, 8'hB6, 1'b1, 1'b0);
    cycle(1'b1, 8'h5A, 1'b1, 1'b0);
    nm = 0;
    for (int k = 0; k < 20 && nm < 3; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      if (sv_s) nm++;
    end
    chk("fl_three_bits", nm, 3);
    cycle(1'b1, 8'hCC, 1'b0, 1'b1);
    chk("fl_ready_low", rdy_s, 0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fl_sv", sv_s, 0); chk("fl_busy", busy_s, 0); chk("fl_ready", rdy_s, 1);
    nbad = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      if (sv_s || busy_s || sv_ls || busy_ls) nbad++;
    end
    chk("fl_quiet", nbad, 0);

    // asynchronous reset mid-word
    cycle(1'b1, 8'hB6, 1'b1, 1'b0);
    nm = 0;
    for (int k = 0; k < 20 && nm < 3; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      if (sv_s) nm++;
    end
    chk("rs_mid_busy", busy_s, 1);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("rs_sv", sv, 0); chk("rs_seq", seq, 0); chk("rs_busy", busy, 0); chk("rs_ready", rdy, 1);
    chk("rs_lsb_busy", busy_l, 0);
    @(negedge clk);
    resetn = 1'b1;
    nbad = 0;
    for (int k = 0; k < 10; k++) begin
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      if (sv_s || busy_s || !rdy_s) nbad++;
    end
    chk("rs_quiet", nbad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
